// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_pkg
// Description : Shared types and constants for the AXI4-Lite register slice
//               (channel buffering modes, skid state encoding, response codes).
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

   // Per-channel buffering mode
   typedef enum logic [1:0] {
      SLICE_BYPASS = 2'd0,
      SLICE_FWD    = 2'd1,
      SLICE_SKID   = 2'd2
   } slice_mode_e;

   // Occupancy of a full skid buffer: main entry is always older than skid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL1 = 2'd1,
      ST_FULL2 = 2'd2
   } skid_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // One strobe bit per data byte
   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_skid_buf
// Description : One generic valid/ready channel stage. MODE selects bypass
//               (wires only), forward register, or two-entry full skid buffer
//               with a registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_skid_buf
   import axi4lite_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int MODE  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   generate
      if (MODE == int'(SLICE_FWD)) begin : g_fwd
         logic             valid_q;
         logic [WIDTH-1:0] data_q;

         // Ready looks through the stage when it is empty or draining this cycle
         assign in_ready  = !rst && (!valid_q || out_ready);
         assign out_valid = valid_q;
         assign out_data  = data_q;

         // Single pipeline register: load on input transfer, clear on output transfer
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q <= 1'b0;
               data_q  <= '0;
            end else if (in_valid && in_ready) begin
               valid_q <= 1'b1;
               data_q  <= in_data;
            end else if (valid_q && out_ready) begin
               valid_q <= 1'b0;
            end
         end

      end else if (MODE == int'(SLICE_SKID)) begin : g_skid
         skid_state_e      state_q, state_d;
         logic [WIDTH-1:0] main_q, main_d;
         logic [WIDTH-1:0] skid_q, skid_d;
         logic             ready_q;
         logic             in_xfer, out_xfer;

         assign in_xfer   = in_valid && ready_q;
         assign out_xfer  = (state_q != ST_EMPTY) && out_ready;
         assign in_ready  = ready_q;
         assign out_valid = (state_q != ST_EMPTY);
         assign out_data  = main_q;

         // Next occupancy and entry contents; skid only fills when the sink stalls
         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
               ST_EMPTY: begin
                  if (in_xfer) begin
                     state_d = ST_FULL1;
                     main_d  = in_data;
                  end
               end
               ST_FULL1: begin
                  if (in_xfer && out_xfer) begin
                     main_d = in_data;
                  end else if (in_xfer) begin
                     skid_d  = in_data;
                     state_d = ST_FULL2;
                  end else if (out_xfer) begin
                     state_d = ST_EMPTY;
                  end
               end
               ST_FULL2: begin
                  if (out_xfer) begin
                     main_d  = skid_q;
                     state_d = ST_FULL1;
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
         end

         // State, entries and the registered ready; ready drops only when both entries hold data
         always_ff @(posedge clk) begin
            if (rst) begin
               state_q <= ST_EMPTY;
               main_q  <= '0;
               skid_q  <= '0;
               ready_q <= 1'b0;
            end else begin
               state_q <= state_d;
               main_q  <= main_d;
               skid_q  <= skid_d;
               ready_q <= (state_d != ST_FULL2);
            end
         end

      end else begin : g_bypass
         logic unused_clk_rst;

         // Pure wires; clock and reset have no effect in this mode
         assign unused_clk_rst = clk ^ rst;
         assign out_valid      = in_valid;
         assign out_data       = in_data;
         assign in_ready       = out_ready;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/axi4lite_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_reg_slice
// Description : AXI4-Lite register slice. Each of AW, W, B, AR, R gets its own
//               buffering stage; request channels flow s->m, responses m->s.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_reg_slice
   import axi4lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int AW_MODE    = 2,
   parameter int W_MODE     = 2,
   parameter int B_MODE     = 2,
   parameter int AR_MODE    = 2,
   parameter int R_MODE     = 2
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_WIDTH-1:0]   s_AWADDR,
   input  logic                    s_AWVALID,
   output logic                    s_AWREADY,
   output logic [ADDR_WIDTH-1:0]   m_AWADDR,
   output logic                    m_AWVALID,
   input  logic                    m_AWREADY,
   input  logic [DATA_WIDTH-1:0]   s_WDATA,
   input  logic [DATA_WIDTH/8-1:0] s_WSTRB,
   input  logic                    s_WVALID,
   output logic                    s_WREADY,
   output logic [DATA_WIDTH-1:0]   m_WDATA,
   output logic [DATA_WIDTH/8-1:0] m_WSTRB,
   output logic                    m_WVALID,
   input  logic                    m_WREADY,
   output logic [1:0]              s_BRESP,
   output logic                    s_BVALID,
   input  logic                    s_BREADY,
   input  logic [1:0]              m_BRESP,
   input  logic                    m_BVALID,
   output logic                    m_BREADY,
   input  logic [ADDR_WIDTH-1:0]   s_ARADDR,
   input  logic                    s_ARVALID,
   output logic                    s_ARREADY,
   output logic [ADDR_WIDTH-1:0]   m_ARADDR,
   output logic                    m_ARVALID,
   input  logic                    m_ARREADY,
   output logic [DATA_WIDTH-1:0]   s_RDATA,
   output logic [1:0]              s_RRESP,
   output logic                    s_RVALID,
   input  logic                    s_RREADY,
   input  logic [DATA_WIDTH-1:0]   m_RDATA,
   input  logic [1:0]              m_RRESP,
   input  logic                    m_RVALID,
   output logic                    m_RREADY
);

   localparam int STRB_W = strb_width(DATA_WIDTH);

   // Write address, upstream to downstream
   axi4lite_skid_buf #(.WIDTH(ADDR_WIDTH), .MODE(AW_MODE)) u_aw (
      .clk       (ACLK),
      .rst       (ARESET),
      .in_valid  (s_AWVALID),
      .in_ready  (s_AWREADY),
      .in_data   (s_AWADDR),
      .out_valid (m_AWVALID),
      .out_ready (m_AWREADY),
      .out_data  (m_AWADDR)
   );

   // Write data with strobes, upstream to downstream
   axi4lite_skid_buf #(.WIDTH(DATA_WIDTH + STRB_W), .MODE(W_MODE)) u_w (
      .clk       (ACLK),
      .rst       (ARESET),
      .in_valid  (s_WVALID),
      .in_ready  (s_WREADY),
      .in_data   ({s_WSTRB, s_WDATA}),
      .out_valid (m_WVALID),
      .out_ready (m_WREADY),
      .out_data  ({m_WSTRB, m_WDATA})
   );

   // Write response, downstream to upstream
   axi4lite_skid_buf #(.WIDTH(2), .MODE(B_MODE)) u_b (
      .clk       (ACLK),
      .rst       (ARESET),
      .in_valid  (m_BVALID),
      .in_ready  (m_BREADY),
      .in_data   (m_BRESP),
      .out_valid (s_BVALID),
      .out_ready (s_BREADY),
      .out_data  (s_BRESP)
   );

   // Read address, upstream to downstream
   axi4lite_skid_buf #(.WIDTH(ADDR_WIDTH), .MODE(AR_MODE)) u_ar (
      .clk       (ACLK),
      .rst       (ARESET),
      .in_valid  (s_ARVALID),
      .in_ready  (s_ARREADY),
      .in_data   (s_ARADDR),
      .out_valid (m_ARVALID),
      .out_ready (m_ARREADY),
      .out_data  (m_ARADDR)
   );

   // Read data with response, downstream to upstream
   axi4lite_skid_buf #(.WIDTH(DATA_WIDTH + 2), .MODE(R_MODE)) u_r (
      .clk       (ACLK),
      .rst       (ARESET),
      .in_valid  (m_RVALID),
      .in_ready  (m_RREADY),
      .in_data   ({m_RRESP, m_RDATA}),
      .out_valid (s_RVALID),
      .out_ready (s_RREADY),
      .out_data  ({s_RRESP, s_RDATA})
   );

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4lite_reg_slice
// Description : Directed self-checking bench for axi4lite_reg_slice. Three
//               instances: A (32b, skid everywhere except forward R),
//               B (all bypass), C (64b/12b address, mixed modes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_reg_slice;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- instance A ----------------
   logic [5:0]  a_s_awaddr, a_m_awaddr, a_s_araddr, a_m_araddr;
   logic [31:0] a_s_wdata, a_m_wdata, a_s_rdata, a_m_rdata;
   logic [3:0]  a_s_wstrb, a_m_wstrb;
   logic [1:0]  a_s_bresp, a_m_bresp, a_s_rresp, a_m_rresp;
   logic a_s_awvalid, a_s_awready, a_m_awvalid, a_m_awready;
   logic a_s_wvalid, a_s_wready, a_m_wvalid, a_m_wready;
   logic a_s_bvalid, a_s_bready, a_m_bvalid, a_m_bready;
   logic a_s_arvalid, a_s_arready, a_m_arvalid, a_m_arready;
   logic a_s_rvalid, a_s_rready, a_m_rvalid, a_m_rready;

   // ---------------- instance B ----------------
   logic [5:0]  b_s_awaddr, b_m_awaddr, b_s_araddr, b_m_araddr;
   logic [31:0] b_s_wdata, b_m_wdata, b_s_rdata, b_m_rdata;
   logic [3:0]  b_s_wstrb, b_m_wstrb;
   logic [1:0]  b_s_bresp, b_m_bresp, b_s_rresp, b_m_rresp;
   logic b_s_awvalid, b_s_awready, b_m_awvalid, b_m_awready;
   logic b_s_wvalid, b_s_wready, b_m_wvalid, b_m_wready;
   logic b_s_bvalid, b_s_bready, b_m_bvalid, b_m_bready;
   logic b_s_arvalid, b_s_arready, b_m_arvalid, b_m_arready;
   logic b_s_rvalid, b_s_rready, b_m_rvalid, b_m_rready;

   // ---------------- instance C ----------------
   logic [11:0] c_s_awaddr, c_m_awaddr, c_s_araddr, c_m_araddr;
   logic [63:0] c_s_wdata, c_m_wdata, c_s_rdata, c_m_rdata;
   logic [7:0]  c_s_wstrb, c_m_wstrb;
   logic [1:0]  c_s_bresp, c_m_bresp, c_s_rresp, c_m_rresp;
   logic c_s_awvalid, c_s_awready, c_m_awvalid, c_m_awready;
   logic c_s_wvalid, c_s_wready, c_m_wvalid, c_m_wready;
   logic c_s_bvalid, c_s_bready, c_m_bvalid, c_m_bready;
   logic c_s_arvalid, c_s_arready, c_m_arvalid, c_m_arready;
   logic c_s_rvalid, c_s_rready, c_m_rvalid, c_m_rready;

   axi4lite_reg_slice #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .AW_MODE(2), .W_MODE(2),
                        .B_MODE(2), .AR_MODE(2), .R_MODE(1)) u_dut_a (
      .ACLK(clk), .ARESET(rst),
      .s_AWADDR(a_s_awaddr), .s_AWVALID(a_s_awvalid), .s_AWREADY(a_s_awready),
      .m_AWADDR(a_m_awaddr), .m_AWVALID(a_m_awvalid), .m_AWREADY(a_m_awready),
      .s_WDATA(a_s_wdata), .s_WSTRB(a_s_wstrb), .s_WVALID(a_s_wvalid), .s_WREADY(a_s_wready),
      .m_WDATA(a_m_wdata), .m_WSTRB(a_m_wstrb), .m_WVALID(a_m_wvalid), .m_WREADY(a_m_wready),
      .s_BRESP(a_s_bresp), .s_BVALID(a_s_bvalid), .s_BREADY(a_s_bready),
      .m_BRESP(a_m_bresp), .m_BVALID(a_m_bvalid), .m_BREADY(a_m_bready),
      .s_ARADDR(a_s_araddr), .s_ARVALID(a_s_arvalid), .s_ARREADY(a_s_arready),
      .m_ARADDR(a_m_araddr), .m_ARVALID(a_m_arvalid), .m_ARREADY(a_m_arready),
      .s_RDATA(a_s_rdata), .s_RRESP(a_s_rresp), .s_RVALID(a_s_rvalid), .s_RREADY(a_s_rready),
      .m_RDATA(a_m_rdata), .m_RRESP(a_m_rresp), .m_RVALID(a_m_rvalid), .m_RREADY(a_m_rready)
   );

   axi4lite_reg_slice #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .AW_MODE(0), .W_MODE(0),
                        .B_MODE(0), .AR_MODE(0), .R_MODE(0)) u_dut_b (
      .ACLK(clk), .ARESET(rst),
      .s_AWADDR(b_s_awaddr), .s_AWVALID(b_s_awvalid), .s_AWREADY(b_s_awready),
      .m_AWADDR(b_m_awaddr), .m_AWVALID(b_m_awvalid), .m_AWREADY(b_m_awready),
      .s_WDATA(b_s_wdata), .s_WSTRB(b_s_wstrb), .s_WVALID(b_s_wvalid), .s_WREADY(b_s_wready),
      .m_WDATA(b_m_wdata), .m_WSTRB(b_m_wstrb), .m_WVALID(b_m_wvalid), .m_WREADY(b_m_wready),
      .s_BRESP(b_s_bresp), .s_BVALID(b_s_bvalid), .s_BREADY(b_s_bready),
      .m_BRESP(b_m_bresp), .m_BVALID(b_m_bvalid), .m_BREADY(b_m_bready),
      .s_ARADDR(b_s_araddr), .s_ARVALID(b_s_arvalid), .s_ARREADY(b_s_arready),
      .m_ARADDR(b_m_araddr), .m_ARVALID(b_m_arvalid), .m_ARREADY(b_m_arready),
      .s_RDATA(b_s_rdata), .s_RRESP(b_s_rresp), .s_RVALID(b_s_rvalid), .s_RREADY(b_s_rready),
      .m_RDATA(b_m_rdata), .m_RRESP(b_m_rresp), .m_RVALID(b_m_rvalid), .m_RREADY(b_m_rready)
   );

   axi4lite_reg_slice #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .AW_MODE(1), .W_MODE(2),
                        .B_MODE(0), .AR_MODE(2), .R_MODE(1)) u_dut_c (
      .ACLK(clk), .ARESET(rst),
      .s_AWADDR(c_s_awaddr), .s_AWVALID(c_s_awvalid), .s_AWREADY(c_s_awready),
      .m_AWADDR(c_m_awaddr), .m_AWVALID(c_m_awvalid), .m_AWREADY(c_m_awready),
      .s_WDATA(c_s_wdata), .s_WSTRB(c_s_wstrb), .s_WVALID(c_s_wvalid), .s_WREADY(c_s_wready),
      .m_WDATA(c_m_wdata), .m_WSTRB(c_m_wstrb), .m_WVALID(c_m_wvalid), .m_WREADY(c_m_wready),
      .s_BRESP(c_s_bresp), .s_BVALID(c_s_bvalid), .s_BREADY(c_s_bready),
      .m_BRESP(c_m_bresp), .m_BVALID(c_m_bvalid), .m_BREADY(c_m_bready),
      .s_ARADDR(c_s_araddr), .s_ARVALID(c_s_arvalid), .s_ARREADY(c_s_arready),
      .m_ARADDR(c_m_araddr), .m_ARVALID(c_m_arvalid), .m_ARREADY(c_m_arready),
      .s_RDATA(c_s_rdata), .s_RRESP(c_s_rresp), .s_RVALID(c_s_rvalid), .s_RREADY(c_s_rready),
      .m_RDATA(c_m_rdata), .m_RRESP(c_m_rresp), .m_RVALID(c_m_rvalid), .m_RREADY(c_m_rready)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard state for instance C
   logic [71:0] q_aw[$], q_w[$], q_b[$], q_ar[$], q_r[$];
   logic [71:0] e;
   logic hs_aw = 1'b0, hs_w = 1'b0, hs_b = 1'b0, hs_ar = 1'b0, hs_r = 1'b0;
   logic gen;
   int   idx, ndel;
   logic [9:0] exp_rdy, exp_sv;

   initial begin
      {a_s_awaddr, a_s_awvalid, a_m_awready, a_s_wdata, a_s_wstrb, a_s_wvalid, a_m_wready} = '0;
      {a_m_bresp, a_m_bvalid, a_s_bready, a_s_araddr, a_s_arvalid, a_m_arready} = '0;
      {a_m_rdata, a_m_rresp, a_m_rvalid, a_s_rready} = '0;
      {b_s_awaddr, b_s_awvalid, b_m_awready, b_s_wdata, b_s_wstrb, b_s_wvalid, b_m_wready} = '0;
      {b_m_bresp, b_m_bvalid, b_s_bready, b_s_araddr, b_s_arvalid, b_m_arready} = '0;
      {b_m_rdata, b_m_rresp, b_m_rvalid, b_s_rready} = '0;
      {c_s_awaddr, c_s_awvalid, c_m_awready, c_s_wdata, c_s_wstrb, c_s_wvalid, c_m_wready} = '0;
      {c_m_bresp, c_m_bvalid, c_s_bready, c_s_araddr, c_s_arvalid, c_m_arready} = '0;
      {c_m_rdata, c_m_rresp, c_m_rvalid, c_s_rready} = '0;

      // ---- reset state ----
      rst = 1'b1;
      a_s_rready = 1'b1;
      tick(); tick(); tick();
      check("rst_awready",  64'(a_s_awready), 64'(0));
      check("rst_m_awvalid", 64'(a_m_awvalid), 64'(0));
      check("rst_wready",   64'(a_s_wready),  64'(0));
      check("rst_s_bvalid", 64'(a_s_bvalid),  64'(0));
      check("rst_fwd_rready", 64'(a_m_rready), 64'(0));
      check("rst_s_rvalid", 64'(a_s_rvalid),  64'(0));
      rst = 1'b0;
      tick();
      check("rel_awready",  64'(a_s_awready), 64'(1));
      check("rel_bready",   64'(a_m_bready),  64'(1));
      check("rel_fwd_rready", 64'(a_m_rready), 64'(1));
      a_s_rready = 1'b0;

      // ---- AW back-to-back through skid ----
      a_m_awready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         a_s_awvalid = 1'b1;
         a_s_awaddr  = 6'(4 * k);
         check("aw_s_ready", 64'(a_s_awready), 64'(1));
         if (k == 0) check("aw_m_valid0", 64'(a_m_awvalid), 64'(0));
         else begin
            check("aw_m_valid", 64'(a_m_awvalid), 64'(1));
            check("aw_m_addr",  64'(a_m_awaddr),  64'(4 * (k - 1)));
         end
         tick();
      end
      a_s_awvalid = 1'b0;
      check("aw_last_valid", 64'(a_m_awvalid), 64'(1));
      check("aw_last_addr",  64'(a_m_awaddr),  64'h1C);
      tick();
      check("aw_drained", 64'(a_m_awvalid), 64'(0));
      a_m_awready = 1'b0;

      // ---- W stall fills both entries ----
      a_m_wready = 1'b0;
      a_s_wvalid = 1'b1; a_s_wdata = 32'hA5A5A5A5; a_s_wstrb = 4'hF;
      check("w_ready_0", 64'(a_s_wready), 64'(1));
      tick();
      a_s_wdata = 32'h5A5A5A5A; a_s_wstrb = 4'h3;
      check("w_ready_1", 64'(a_s_wready), 64'(1));
      check("w_m_valid_1", 64'(a_m_wvalid), 64'(1));
      check("w_m_data_1", 64'(a_m_wdata), 64'hA5A5A5A5);
      check("w_m_strb_1", 64'(a_m_wstrb), 64'hF);
      tick();
      a_s_wvalid = 1'b0;
      check("w_ready_full", 64'(a_s_wready), 64'(0));
      tick();
      check("w_ready_hold", 64'(a_s_wready), 64'(0));
      check("w_m_data_hold", 64'(a_m_wdata), 64'hA5A5A5A5);
      a_m_wready = 1'b1;
      tick();
      check("w_m_valid_2", 64'(a_m_wvalid), 64'(1));
      check("w_m_data_2", 64'(a_m_wdata), 64'h5A5A5A5A);
      check("w_m_strb_2", 64'(a_m_wstrb), 64'h3);
      check("w_ready_back", 64'(a_s_wready), 64'(1));
      tick();
      check("w_drained", 64'(a_m_wvalid), 64'(0));
      check("w_ready_idle", 64'(a_s_wready), 64'(1));
      a_m_wready = 1'b0;

      // ---- R forward stage with toggling sink ready ----
      exp_rdy = 10'b1101010101;
      exp_sv  = 10'b0111111110;
      idx = 0; ndel = 0;
      for (int c = 0; c < 10; c++) begin
         a_s_rready = (c % 2 == 0);
         a_m_rvalid = (idx < 4);
         a_m_rdata  = 32'hD0 + 32'(idx);
         a_m_rresp  = 2'b10;
         #1;
         check("r_m_ready", 64'(a_m_rready), 64'(exp_rdy[c]));
         check("r_s_valid", 64'(a_s_rvalid), 64'(exp_sv[c]));
         if (a_m_rvalid && a_m_rready) idx++;
         if (a_s_rvalid && a_s_rready) begin
            check("r_s_data", 64'(a_s_rdata), 64'(32'hD0 + 32'(ndel)));
            check("r_s_resp", 64'(a_s_rresp), 64'(2'b10));
            ndel++;
         end
         tick();
      end
      check("r_delivered", 64'(ndel), 64'(4));
      a_s_rready = 1'b0; a_m_rvalid = 1'b0;

      // ---- B fills to FULL2 then reset discards it ----
      a_s_bready = 1'b0;
      a_m_bvalid = 1'b1; a_m_bresp = 2'b01;
      check("b_ready_0", 64'(a_m_bready), 64'(1));
      tick();
      a_m_bresp = 2'b11;
      check("b_ready_1", 64'(a_m_bready), 64'(1));
      check("b_s_resp_1", 64'(a_s_bresp), 64'(2'b01));
      tick();
      a_m_bvalid = 1'b0;
      check("b_ready_full", 64'(a_m_bready), 64'(0));
      check("b_s_valid_full", 64'(a_s_bvalid), 64'(1));
      rst = 1'b1;
      tick();
      check("b_rst_valid", 64'(a_s_bvalid), 64'(0));
      check("b_rst_resp", 64'(a_s_bresp), 64'(0));
      check("b_rst_ready", 64'(a_m_bready), 64'(0));
      check("b_rst_fwd_ready", 64'(a_m_rready), 64'(0));
      rst = 1'b0;
      a_s_bready = 1'b1;
      tick();
      check("b_rel_ready", 64'(a_m_bready), 64'(1));
      check("b_rel_valid", 64'(a_s_bvalid), 64'(0));
      tick();
      check("b_no_stale", 64'(a_s_bvalid), 64'(0));
      a_s_bready = 1'b0;

      // ---- bypass: outputs follow inputs in the same cycle ----
      for (int c = 0; c < 1000; c++) begin
         b_s_awaddr = 6'($urandom);  b_s_awvalid = 1'($urandom); b_m_awready = 1'($urandom);
         b_s_wdata  = $urandom;      b_s_wstrb   = 4'($urandom); b_s_wvalid  = 1'($urandom);
         b_m_wready = 1'($urandom);  b_m_bresp   = 2'($urandom); b_m_bvalid  = 1'($urandom);
         b_s_bready = 1'($urandom);  b_s_araddr  = 6'($urandom); b_s_arvalid = 1'($urandom);
         b_m_arready = 1'($urandom); b_m_rdata   = $urandom;     b_m_rresp   = 2'($urandom);
         b_m_rvalid = 1'($urandom);  b_s_rready  = 1'($urandom);
         rst = (c == 500);
         #1;
         check("byp_aw_b_ar",
               64'({b_m_awaddr, b_m_awvalid, b_s_awready, b_s_bresp, b_s_bvalid, b_m_bready,
                    b_m_araddr, b_m_arvalid, b_s_arready}),
               64'({b_s_awaddr, b_s_awvalid, b_m_awready, b_m_bresp, b_m_bvalid, b_s_bready,
                    b_s_araddr, b_s_arvalid, b_m_arready}));
         check("byp_w", 64'({b_m_wdata, b_m_wstrb, b_m_wvalid, b_s_wready}),
                        64'({b_s_wdata, b_s_wstrb, b_s_wvalid, b_m_wready}));
         check("byp_r", 64'({b_s_rdata, b_s_rresp, b_s_rvalid, b_m_rready}),
                        64'({b_m_rdata, b_m_rresp, b_m_rvalid, b_s_rready}));
         tick();
      end
      rst = 1'b0;
      tick();

      // ---- mixed-mode 64-bit scoreboard ----
      for (int c = 0; c < 340; c++) begin
         gen = (c < 300);
         if (!c_s_awvalid || hs_aw) begin
            c_s_awvalid = gen && 1'($urandom); c_s_awaddr = 12'($urandom);
         end
         if (!c_s_wvalid || hs_w) begin
            c_s_wvalid = gen && 1'($urandom); c_s_wdata = {$urandom, $urandom};
            c_s_wstrb = 8'($urandom);
         end
         if (!c_m_bvalid || hs_b) begin
            c_m_bvalid = gen && 1'($urandom); c_m_bresp = 2'($urandom);
         end
         if (!c_s_arvalid || hs_ar) begin
            c_s_arvalid = gen && 1'($urandom); c_s_araddr = 12'($urandom);
         end
         if (!c_m_rvalid || hs_r) begin
            c_m_rvalid = gen && 1'($urandom); c_m_rdata = {$urandom, $urandom};
            c_m_rresp = 2'($urandom);
         end
         c_m_awready = !gen || 1'($urandom);
         c_m_wready  = !gen || 1'($urandom);
         c_s_bready  = !gen || 1'($urandom);
         c_m_arready = !gen || 1'($urandom);
         c_s_rready  = !gen || 1'($urandom);

         @(negedge clk);
         hs_aw = c_s_awvalid && c_s_awready;
         hs_w  = c_s_wvalid && c_s_wready;
         hs_b  = c_m_bvalid && c_m_bready;
         hs_ar = c_s_arvalid && c_s_arready;
         hs_r  = c_m_rvalid && c_m_rready;
         if (hs_aw) q_aw.push_back(72'(c_s_awaddr));
         if (hs_w)  q_w.push_back({c_s_wstrb, c_s_wdata});
         if (hs_b)  q_b.push_back(72'(c_m_bresp));
         if (hs_ar) q_ar.push_back(72'(c_s_araddr));
         if (hs_r)  q_r.push_back(72'({c_m_rresp, c_m_rdata}));

         if (c_m_awvalid && c_m_awready) begin
            check("c_aw_sb_nonempty", 64'(q_aw.size() != 0), 64'(1));
            if (q_aw.size() != 0) begin
               e = q_aw.pop_front();
               check("c_aw_addr", 64'(c_m_awaddr), e[63:0]);
            end
         end
         if (c_m_wvalid && c_m_wready) begin
            check("c_w_sb_nonempty", 64'(q_w.size() != 0), 64'(1));
            if (q_w.size() != 0) begin
               e = q_w.pop_front();
               check("c_w_data", c_m_wdata, e[63:0]);
               check("c_w_strb", 64'(c_m_wstrb), 64'(e[71:64]));
            end
         end
         if (c_s_bvalid && c_s_bready) begin
            check("c_b_sb_nonempty", 64'(q_b.size() != 0), 64'(1));
            if (q_b.size() != 0) begin
               e = q_b.pop_front();
               check("c_b_resp", 64'(c_s_bresp), e[63:0]);
            end
         end
         if (c_m_arvalid && c_m_arready) begin
            check("c_ar_sb_nonempty", 64'(q_ar.size() != 0), 64'(1));
            if (q_ar.size() != 0) begin
               e = q_ar.pop_front();
               check("c_ar_addr", 64'(c_m_araddr), e[63:0]);
            end
         end
         if (c_s_rvalid && c_s_rready) begin
            check("c_r_sb_nonempty", 64'(q_r.size() != 0), 64'(1));
            if (q_r.size() != 0) begin
               e = q_r.pop_front();
               check("c_r_data", c_s_rdata, e[63:0]);
               check("c_r_resp", 64'(c_s_rresp), 64'(e[65:64]));
            end
         end
         @(posedge clk);
         #1;
      end
      check("c_aw_left", 64'(q_aw.size()), 64'(0));
      check("c_w_left",  64'(q_w.size()),  64'(0));
      check("c_b_left",  64'(q_b.size()),  64'(0));
      check("c_ar_left", 64'(q_ar.size()), 64'(0));
      check("c_r_left",  64'(q_r.size()),  64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi4lite_reg_slice.md
Name: axi4lite_reg_slice

Overview:
Parametrised AXI4-Lite register slice that breaks timing paths between an AXI4-Lite master and slave, such as the interconnect and the slave memory.
Each of the five channels (AW, W, B, AR, R) has its own buffering mode: bypass, forward-registered, or full skid buffer.
Payload is passed through unchanged; the slice never creates, drops, reorders or modifies transfers.
Data and address widths are generic.

Parameters:
ADDR_WIDTH, 6, AWADDR/ARADDR width
DATA_WIDTH, 32, WDATA/RDATA width; must be 32 or 64; strobe width is DATA_WIDTH/8
AW_MODE, 2, AW channel mode: 0=bypass, 1=forward, 2=full skid
W_MODE, 2, W channel mode, same encoding
B_MODE, 2, B channel mode, same encoding
AR_MODE, 2, AR channel mode, same encoding
R_MODE, 2, R channel mode, same encoding

Ports:
ACLK  in  1  clock; all logic rising-edge
ARESET  in  1  synchronous reset, active-high
s_AWADDR,s_AWVALID / s_AWREADY  in / out  ADDR_WIDTH,1 / 1  upstream AW
m_AWADDR,m_AWVALID / m_AWREADY  out / in  ADDR_WIDTH,1 / 1  downstream AW
s_WDATA,s_WSTRB,s_WVALID / s_WREADY  in / out  DATA_WIDTH,DATA_WIDTH/8,1 / 1  upstream W
m_WDATA,m_WSTRB,m_WVALID / m_WREADY  out / in  same widths  downstream W
s_BRESP,s_BVALID / s_BREADY  out / in  2,1 / 1  upstream B
m_BRESP,m_BVALID / m_BREADY  in / out  2,1 / 1  downstream B
s_ARADDR,s_ARVALID / s_ARREADY  in / out  ADDR_WIDTH,1 / 1  upstream AR
m_ARADDR,m_ARVALID / m_ARREADY  out / in  ADDR_WIDTH,1 / 1  downstream AR
s_RDATA,s_RRESP,s_RVALID / s_RREADY  out / in  DATA_WIDTH,2,1 / 1  upstream R
m_RDATA,m_RRESP,m_RVALID / m_RREADY  in / out  DATA_WIDTH,2,1 / 1  downstream R

Behaviour:
- Generic per-channel view: the source side is in_valid/in_ready/in_data and the sink side is out_valid/out_ready/out_data. Request channels (AW, W, AR) run s->m. Response channels (B, R) run m->s.
- A transfer occurs on a cycle where valid && ready are both high at the rising edge. Valid, once asserted, stays asserted with stable payload until accepted.
- Mode 0 (bypass): out = in and in_ready = out_ready, combinationally. The channel holds no state and ignores ARESET.
- Mode 1 (forward):
  - One register stage holding valid_q and data_q.
  - in_ready = !ARESET && (!valid_q || out_ready), combinational from out_ready.
  - On an input transfer, valid_q<=1 and data_q<=in_data. Otherwise, on an output transfer, valid_q<=0.
  - Latency is 1 cycle. Throughput is 1 transfer/cycle.
- Mode 2 (full skid):
  - Two entries, main and skid. in_ready is a register, so no combinational path exists in either direction.
  - States:
    - EMPTY: main empty. An input transfer goes to FULL1.
    - FULL1: main valid. Input with no output -> FULL1 if out_ready, else capture into skid -> FULL2. Output with no input -> EMPTY.
    - FULL2: both valid, in_ready_q=0. An output transfer moves skid to main -> FULL1.
  - in_ready_q <= (next state != FULL2).
  - Latency is 1 cycle. Sustained throughput is 1/cycle.
  - Order is preserved: the main entry is always older than skid.
- Reset (modes 1, 2): ARESET high at an edge clears every valid and skid-valid register and all payload registers to 0, and forces in_ready to 0.
- Out of reset: in_ready goes to 1 in the first cycle after ARESET deasserts (mode 2: registered 1 at the first edge with ARESET low).
- Reset mid-operation discards all buffered transfers without a handshake. Outputs during and after reset: out_valid=0 and payload 0.
- Simultaneous in and out transfer in FULL1: data passes through main, the state stays FULL1, and skid is untouched.
- out_valid never deasserts without an out handshake, except on ARESET.
- No AW/W coupling: the W channel may lead or lag AW arbitrarily.

Decomposition:
- Shared package axi4lite_pkg holds:
  - slice_mode_e enum {SLICE_BYPASS=0, SLICE_FWD=1, SLICE_SKID=2};
  - RESP_OKAY / RESP_EXOKAY / RESP_SLVERR / RESP_DECERR localparams (2-bit);
  - a function strb_width(DATA_WIDTH).
- Sub-module axi4lite_skid_buf #(WIDTH, MODE) implements one generic channel.
- The top instantiates it five times, once per channel, with the payload concatenated per channel (e.g. {WSTRB,WDATA}).

Test Plan:
- All modes=2; 8 back-to-back AW writes with addresses 0x00..0x1C step 4; m_AWREADY=1 -> m_AWVALID goes high 1 cycle after the first accept; 8 transfers in 8 consecutive cycles, in order.
- Mode 2 W channel; m_WREADY held 0 while s_WVALID stays high with WDATA=0xA5A5A5A5 then 0x5A5A5A5A, WSTRB=0xF, 0x3 -> s_WREADY falls after 2 accepts; release m_WREADY -> both words are emitted in order, then s_WREADY=1.
- Mode 1 R channel; s_RREADY toggles 1,0,1,0 with RRESP=SLVERR(2'b10) -> every response is delivered exactly once with RRESP=2'b10; m_RREADY follows !valid_q||s_RREADY in the same cycle.
- Mode 0 on all channels -> every output equals its input in the same cycle for random stimulus over 1000 cycles; no latency.
- ARESET asserted for 1 cycle while the B channel is in FULL2 -> next cycle s_BVALID=0, m_BREADY=0; one cycle after release m_BREADY=1; the stale BRESP is never emitted.
- DATA_WIDTH=64, ADDR_WIDTH=12, mixed modes (AW=1, W=2, B=0, AR=2, R=1) -> a scoreboard shows all payload bits, including WSTRB[7:0], are preserved.
